// File: rtl/cdb_broadcast.sv
// Common Data Bus arbiter/driver: picks up to SS_SIZE completion tags per cycle
// round-robin across functional units, holding losers in a one-entry per-FU slot.
module cdb_broadcast #(
  parameter int NUM_FU  = 5,
  parameter int SS_SIZE = 2,
  parameter int TAG_W   = 6,
  localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            branch_not_taken,
  input  logic [NUM_FU-1:0]               done_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]    done_tag,
  output logic [NUM_FU-1:0]               fu_stall,
  output logic [SS_SIZE-1:0]              cdb_en,
  output logic [SS_SIZE-1:0][TAG_W:0]     cdb_tag
);

  logic [NUM_FU-1:0]              slot_valid_reg;
  logic [NUM_FU-1:0]              slot_valid_next;
  logic [NUM_FU-1:0][TAG_W-1:0]   slot_tag_reg;
  logic [NUM_FU-1:0][TAG_W-1:0]   slot_tag_next;
  logic [PTR_W-1:0]               rr_ptr_reg;
  logic [PTR_W-1:0]               rr_ptr_next;

  logic [NUM_FU-1:0]              req;
  logic [NUM_FU-1:0]              grant;
  logic [NUM_FU-1:0][TAG_W-1:0]   src_tag;
  logic [SS_SIZE-1:0]             lane_en_next;
  logic [SS_SIZE-1:0][TAG_W:0]    lane_tag_next;

  assign fu_stall = slot_valid_reg;

  // A held slot always wins over the live input; a live input on a stalled FU is ignored.
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    assign req[gi]     = slot_valid_reg[gi] | (done_valid[gi] & ~slot_valid_reg[gi]);
    assign src_tag[gi] = slot_valid_reg[gi] ? slot_tag_reg[gi] : done_tag[gi];

    always_comb begin
      slot_valid_next[gi] = req[gi] & ~grant[gi];
      slot_tag_next[gi]   = slot_tag_reg[gi];
      if (req[gi] && !grant[gi]) begin
        slot_tag_next[gi] = src_tag[gi];
      end
    end
  end

  // Rotating scan from rr_ptr; grants pack into the lowest free lane in scan order.
  always_comb begin
    int               idx;
    int               cnt;
    logic             any_grant;
    logic [PTR_W-1:0] last_idx;

    grant         = '0;
    lane_en_next  = '0;
    lane_tag_next = '0;
    cnt           = 0;
    idx           = 0;
    any_grant     = 1'b0;
    last_idx      = rr_ptr_reg;

    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(rr_ptr_reg) + j;
      if (idx >= NUM_FU) begin
        idx = idx - NUM_FU;
      end
      if (req[idx] && (cnt < SS_SIZE)) begin
        grant[idx]         = 1'b1;
        lane_en_next[cnt]  = 1'b1;
        lane_tag_next[cnt] = {1'b1, src_tag[idx]};
        cnt                = cnt + 1;
        any_grant          = 1'b1;
        last_idx           = idx[PTR_W-1:0];
      end
    end

    rr_ptr_next = rr_ptr_reg;
    if (any_grant) begin
      if (last_idx == PTR_W'(NUM_FU - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = last_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid_reg <= '0;
      slot_tag_reg   <= '0;
      rr_ptr_reg     <= '0;
      cdb_en         <= '0;
      cdb_tag        <= '0;
    end else if (branch_not_taken) begin
      // Squash: drop held and incoming completions, keep the fairness pointer.
      slot_valid_reg <= '0;
      cdb_en         <= '0;
      cdb_tag        <= '0;
    end else begin
      slot_valid_reg <= slot_valid_next;
      slot_tag_reg   <= slot_tag_next;
      rr_ptr_reg     <= rr_ptr_next;
      cdb_en         <= lane_en_next;
      cdb_tag        <= lane_tag_next;
    end
  end

`ifndef SYNTHESIS
  a_no_done_while_stalled: assert property (
    @(posedge clock) disable iff (!reset) ((done_valid & slot_valid_reg) == '0)
  );
`endif

endmodule

// File: tb/tb_cdb_broadcast.sv
// Directed checks of cdb_broadcast: reset, latency, overflow, fairness, flush, async reset.
module tb_cdb_broadcast;
  localparam int NUM_FU  = 5;
  localparam int SS_SIZE = 2;
  localparam int TAG_W   = 6;

  logic                           clock = 1'b0;
  logic                           reset = 1'b0;
  logic                           branch_not_taken = 1'b0;
  logic [NUM_FU-1:0]              done_valid = '0;
  logic [NUM_FU-1:0][TAG_W-1:0]   done_tag = '0;
  logic [NUM_FU-1:0]              fu_stall;
  logic [SS_SIZE-1:0]             cdb_en;
  logic [SS_SIZE-1:0][TAG_W:0]    cdb_tag;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cdb_broadcast #(.NUM_FU(NUM_FU), .SS_SIZE(SS_SIZE), .TAG_W(TAG_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .branch_not_taken (branch_not_taken),
    .done_valid       (done_valid),
    .done_tag         (done_tag),
    .fu_stall         (fu_stall),
    .cdb_en           (cdb_en),
    .cdb_tag          (cdb_tag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    branch_not_taken = 1'b0;
    done_valid       = '0;
    done_tag         = '0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"},    32'(cdb_en),   32'd0);
    check({tag, "_tag"},   32'(cdb_tag),  32'd0);
    check({tag, "_stall"}, 32'(fu_stall), 32'd0);
  endtask

  logic [63:0]      seen;
  int               sent;
  int               seq      [NUM_FU];
  logic [TAG_W-1:0] last_tag [NUM_FU];

  task automatic mark_seen();
    for (int l = 0; l < SS_SIZE; l++) begin
      if (cdb_en[l]) begin
        check("fair_dup", 32'(seen[cdb_tag[l][TAG_W-1:0]]), 32'd0);
        seen[cdb_tag[l][TAG_W-1:0]] = 1'b1;
      end
    end
  endtask

  task automatic drive_unstalled();
    for (int f = 0; f < NUM_FU; f++) begin
      if (!fu_stall[f]) begin
        done_valid[f] = 1'b1;
        last_tag[f]   = TAG_W'(f * 8 + seq[f]);
        done_tag[f]   = last_tag[f];
        seq[f]++;
        sent++;
      end else begin
        done_valid[f] = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset held with random traffic
    for (int i = 0; i < 4; i++) begin
      done_valid = NUM_FU'($urandom);
      done_tag   = (NUM_FU*TAG_W)'($urandom);
      cyc();
      check_idle("rst_hold");
    end
    reset      = 1'b1;
    done_valid = '0;
    cyc();
    check_idle("rst_release");
    $display("reset: held and released");

    // Single completion
    do_reset();
    done_valid  = 5'b00100;
    done_tag[2] = 6'd13;
    cyc();
    done_valid = '0;
    check("single_en",    32'(cdb_en),         32'b01);
    check("single_lane0", 32'(cdb_tag[0]),     32'b1001101);
    check("single_lane1", 32'(cdb_tag[1]),     32'd0);
    check("single_stall", 32'(fu_stall),       32'd0);
    check("single_ptr",   32'(dut.rr_ptr_reg), 32'd3);
    $display("single: FU2 tag 13 broadcast on lane 0");

    // Overflow: three requests, two lanes
    do_reset();
    done_valid  = 5'b01011;
    done_tag[0] = 6'd5;
    done_tag[1] = 6'd6;
    done_tag[3] = 6'd7;
    cyc();
    done_valid = '0;
    check("ovf1_en",    32'(cdb_en),         32'b11);
    check("ovf1_lane0", 32'(cdb_tag[0]),     32'h45);
    check("ovf1_lane1", 32'(cdb_tag[1]),     32'h46);
    check("ovf1_stall", 32'(fu_stall),       32'b01000);
    check("ovf1_ptr",   32'(dut.rr_ptr_reg), 32'd2);
    cyc();
    check("ovf2_en",    32'(cdb_en),         32'b01);
    check("ovf2_lane0", 32'(cdb_tag[0]),     32'h47);
    check("ovf2_lane1", 32'(cdb_tag[1]),     32'd0);
    check("ovf2_stall", 32'(fu_stall),       32'd0);
    check("ovf2_ptr",   32'(dut.rr_ptr_reg), 32'd4);
    $display("overflow: FU3 held one cycle then broadcast");

    // Fairness: every unstalled FU completes every cycle
    do_reset();
    seen = '0;
    sent = 0;
    for (int f = 0; f < NUM_FU; f++) seq[f] = 0;
    drive_unstalled();
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("fair_en",    32'(cdb_en),     32'b11);
      check("fair_lane0", 32'(cdb_tag[0]), 32'({1'b1, last_tag[(2*k) % NUM_FU]}));
      check("fair_lane1", 32'(cdb_tag[1]), 32'({1'b1, last_tag[(2*k+1) % NUM_FU]}));
      mark_seen();
      $display("fair: cycle %0d lanes FU%0d FU%0d", k, (2*k) % NUM_FU, (2*k+1) % NUM_FU);
      if (k < 9) drive_unstalled();
      else done_valid = '0;
    end
    repeat (3) begin
      cyc();
      mark_seen();
    end
    check("fair_all_seen", 32'($countones(seen)), 32'(sent));
    check("fair_drained",  32'(fu_stall),         32'd0);

    // Flush with FU3/FU4 held and a new FU0 completion
    do_reset();
    done_valid  = 5'b11011;
    done_tag[0] = 6'd10;
    done_tag[1] = 6'd11;
    done_tag[3] = 6'd33;
    done_tag[4] = 6'd34;
    cyc();
    check("fl_pre_en",    32'(cdb_en),     32'b11);
    check("fl_pre_lane0", 32'(cdb_tag[0]), 32'h4a);
    check("fl_pre_lane1", 32'(cdb_tag[1]), 32'h4b);
    check("fl_pre_stall", 32'(fu_stall),   32'b11000);
    branch_not_taken = 1'b1;
    done_valid       = 5'b00001;
    done_tag[0]      = 6'd40;
    cyc();
    branch_not_taken = 1'b0;
    done_valid       = '0;
    check_idle("fl_post");
    check("fl_ptr", 32'(dut.rr_ptr_reg), 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("fl_quiet_en", 32'(cdb_en), 32'd0);
    end
    $display("flush: tags 33 34 40 squashed");

    // Asynchronous reset between edges
    do_reset();
    done_valid = 5'b11111;
    for (int f = 0; f < NUM_FU; f++) done_tag[f] = TAG_W'(f + 1);
    cyc();
    done_valid = '0;
    check("ar_pre_en",    32'(cdb_en),   32'b11);
    check("ar_pre_stall", 32'(fu_stall), 32'b11100);
    #2 reset = 1'b0;
    #1;
    check_idle("ar_async");
    cyc();
    reset = 1'b1;
    cyc();
    check_idle("ar_after");
    $display("async_reset: outputs cleared before next edge");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
